// File: rtl/dpram_tdp.sv
// True dual-port RAM, byte enables, registered reads with valid strobes, read-first collisions
// and a post-reset clear sweep. Define OUTPUT_REG_EN for a second output register (read latency 2).
module dpram_tdp #(
  parameter  int Data_Width = 8,
  parameter  int RAM_Depth  = 16,
  localparam int BE_Width   = Data_Width / 8,
  localparam int AW         = (RAM_Depth > 1) ? $clog2(RAM_Depth) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_a,
  input  logic                  cs_b,
  input  logic                  wr_en_a,
  input  logic                  wr_en_b,
  input  logic                  oe_a,
  input  logic                  oe_b,
  input  logic [BE_Width-1:0]   be_a,
  input  logic [BE_Width-1:0]   be_b,
  input  logic [AW-1:0]         addr_a,
  input  logic [AW-1:0]         addr_b,
  input  logic [Data_Width-1:0] data_in_a,
  input  logic [Data_Width-1:0] data_in_b,
  output logic [Data_Width-1:0] data_out_a,
  output logic [Data_Width-1:0] data_out_b,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic                  collision,
  output logic                  init_done
);

  // state | meaning
  // CLEAR | sweeping one word per cycle to zero, port requests ignored
  // READY | normal dual-port operation, terminal until reset
  typedef enum logic {CLEAR, READY} state_e;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(RAM_Depth);
  localparam logic [AW-1:0] LAST_C  = AW'(RAM_Depth - 1);

  logic [Data_Width-1:0] mem_q [RAM_Depth];

  state_e                state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic                  ready, in_a, in_b, wr_a, wr_b, rd_a, rd_b;
  logic [Data_Width-1:0] rdata_a, rdata_b;
  logic [Data_Width-1:0] d1_a_q, d1_a_d, d1_b_q, d1_b_d;
  logic                  v1_a_q, v1_b_q;
  logic                  coll_q, coll_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == LAST_C) begin
          state_d = READY;
          ptr_d   = '0;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    ready   = (state_q == READY);
    in_a    = ({1'b0, addr_a} < DEPTH_C);
    in_b    = ({1'b0, addr_b} < DEPTH_C);
    wr_a    = ready & cs_a & wr_en_a & in_a;
    wr_b    = ready & cs_b & wr_en_b & in_b;
    rd_a    = ready & cs_a & oe_a & ~wr_en_a;
    rd_b    = ready & cs_b & oe_b & ~wr_en_b;
    rdata_a = in_a ? mem_q[addr_a] : '0;
    rdata_b = in_b ? mem_q[addr_b] : '0;
    d1_a_d  = rd_a ? rdata_a : d1_a_q;
    d1_b_d  = rd_b ? rdata_b : d1_b_q;
    coll_d  = ready & cs_a & cs_b & (wr_en_a | oe_a) & (wr_en_b | oe_b)
            & (addr_a == addr_b) & (wr_en_a | wr_en_b);
  end

  // Port B bytes are written first so a port A byte on the same address overrides them.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int i = 0; i < BE_Width; i++) begin
        if (wr_b && be_b[i]) mem_q[addr_b][8*i +: 8] <= data_in_b[8*i +: 8];
      end
      for (int i = 0; i < BE_Width; i++) begin
        if (wr_a && be_a[i]) mem_q[addr_a][8*i +: 8] <= data_in_a[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_a_q <= '0;
      d1_b_q <= '0;
      v1_a_q <= 1'b0;
      v1_b_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      d1_a_q <= d1_a_d;
      d1_b_q <= d1_b_d;
      v1_a_q <= rd_a;
      v1_b_q <= rd_b;
      coll_q <= coll_d;
    end
  end

`ifdef OUTPUT_REG_EN
  logic [Data_Width-1:0] d2_a_q, d2_a_d, d2_b_q, d2_b_d;
  logic                  v2_a_q, v2_b_q;

  always_comb begin
    d2_a_d = v1_a_q ? d1_a_q : d2_a_q;
    d2_b_d = v1_b_q ? d1_b_q : d2_b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d2_a_q <= '0;
      d2_b_q <= '0;
      v2_a_q <= 1'b0;
      v2_b_q <= 1'b0;
    end else begin
      d2_a_q <= d2_a_d;
      d2_b_q <= d2_b_d;
      v2_a_q <= v1_a_q;
      v2_b_q <= v1_b_q;
    end
  end

  assign data_out_a = d2_a_q;
  assign data_out_b = d2_b_q;
  assign valid_a    = v2_a_q;
  assign valid_b    = v2_b_q;
`else
  assign data_out_a = d1_a_q;
  assign data_out_b = d1_b_q;
  assign valid_a    = v1_a_q;
  assign valid_b    = v1_b_q;
`endif

  assign collision = coll_q;
  assign init_done = ready;

endmodule

// File: tb/tb_dpram_tdp.sv
// Directed bench for dpram_tdp: an 8-bit/16-word instance and a 16-bit/12-word instance
// (byte lanes and out-of-range addresses). Latency follows OUTPUT_REG_EN.
module tb_dpram_tdp;

`ifdef OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cs_a, cs_b, wr_en_a, wr_en_b, oe_a, oe_b;
  logic [0:0] be_a, be_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] din_a, din_b, dout_a, dout_b;
  logic       valid_a, valid_b, collision, init_done;

  logic        w_cs_a, w_cs_b, w_wr_a, w_wr_b, w_oe_a, w_oe_b;
  logic [1:0]  w_be_a, w_be_b;
  logic [3:0]  w_addr_a, w_addr_b;
  logic [15:0] w_din_a, w_din_b, w_dout_a, w_dout_b;
  logic        w_valid_a, w_valid_b, w_collision, w_init_done;

  int tests = 0;
  int fails = 0;

  dpram_tdp #(.Data_Width(8), .RAM_Depth(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cs_a(cs_a), .cs_b(cs_b), .wr_en_a(wr_en_a), .wr_en_b(wr_en_b),
    .oe_a(oe_a), .oe_b(oe_b), .be_a(be_a), .be_b(be_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_in_a(din_a), .data_in_b(din_b),
    .data_out_a(dout_a), .data_out_b(dout_b), .valid_a(valid_a), .valid_b(valid_b),
    .collision(collision), .init_done(init_done)
  );

  dpram_tdp #(.Data_Width(16), .RAM_Depth(12)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .cs_a(w_cs_a), .cs_b(w_cs_b), .wr_en_a(w_wr_a), .wr_en_b(w_wr_b),
    .oe_a(w_oe_a), .oe_b(w_oe_b), .be_a(w_be_a), .be_b(w_be_b),
    .addr_a(w_addr_a), .addr_b(w_addr_b), .data_in_a(w_din_a), .data_in_b(w_din_b),
    .data_out_a(w_dout_a), .data_out_b(w_dout_b), .valid_a(w_valid_a), .valid_b(w_valid_b),
    .collision(w_collision), .init_done(w_init_done)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic idle_all();
    cs_a = 0; cs_b = 0; wr_en_a = 0; wr_en_b = 0; oe_a = 0; oe_b = 0;
    be_a = 1'b1; be_b = 1'b1; addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    w_cs_a = 0; w_cs_b = 0; w_wr_a = 0; w_wr_b = 0; w_oe_a = 0; w_oe_b = 0;
    w_be_a = 2'b11; w_be_b = 2'b11; w_addr_a = '0; w_addr_b = '0; w_din_a = '0; w_din_b = '0;
  endtask

  task automatic wr8(input bit pb, input logic [3:0] a, input logic [7:0] d, input logic be);
    @(negedge clk);
    if (pb) begin cs_b = 1; wr_en_b = 1; oe_b = 0; addr_b = a; din_b = d; be_b = be; end
    else    begin cs_a = 1; wr_en_a = 1; oe_a = 0; addr_a = a; din_a = d; be_a = be; end
    @(negedge clk);
    idle_all();
  endtask

  task automatic rd8(input bit pb, input logic [3:0] a, output logic [7:0] d, output int lat);
    @(negedge clk);
    if (pb) begin cs_b = 1; wr_en_b = 0; oe_b = 1; addr_b = a; end
    else    begin cs_a = 1; wr_en_a = 0; oe_a = 1; addr_a = a; end
    lat = 0;
    d = 'x;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) idle_all();
      if (pb && valid_b)  begin lat = c; d = dout_b; end
      if (!pb && valid_a) begin lat = c; d = dout_a; end
      if (lat != 0) break;
    end
  endtask

  task automatic wr16(input bit pb, input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    if (pb) begin w_cs_b = 1; w_wr_b = 1; w_addr_b = a; w_din_b = d; w_be_b = be; end
    else    begin w_cs_a = 1; w_wr_a = 1; w_addr_a = a; w_din_a = d; w_be_a = be; end
    @(negedge clk);
    idle_all();
  endtask

  task automatic rd16(input bit pb, input logic [3:0] a, output logic [15:0] d, output int lat);
    @(negedge clk);
    if (pb) begin w_cs_b = 1; w_oe_b = 1; w_addr_b = a; end
    else    begin w_cs_a = 1; w_oe_a = 1; w_addr_a = a; end
    lat = 0;
    d = 'x;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) idle_all();
      if (pb && w_valid_b)  begin lat = c; d = w_dout_b; end
      if (!pb && w_valid_a) begin lat = c; d = w_dout_a; end
      if (lat != 0) break;
    end
  endtask

  task automatic wait_ready(output int n8, output int n16);
    n8 = 0;
    n16 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (init_done && n8 == 0) n8 = k;
      if (w_init_done && n16 == 0) n16 = k;
      if (n8 != 0 && n16 != 0) break;
    end
  endtask

  task automatic test_reset();
    int n8, n16, lat;
    logic [7:0] d;
    idle_all();
    rst_n = 0;
    repeat (3) @(negedge clk);
    tests++; if (dout_a !== 8'h00) begin fails++; $display("FAIL reset_dout_a: got %h want 00", dout_a); end
    tests++; if (dout_b !== 8'h00) begin fails++; $display("FAIL reset_dout_b: got %h want 00", dout_b); end
    tests++; if ({valid_a, valid_b, collision} !== 3'b000) begin fails++; $display("FAIL reset_strobes: got %b want 000", {valid_a, valid_b, collision}); end
    tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    rst_n = 1;
    wait_ready(n8, n16);
    tests++; if (n8 != 16) begin fails++; $display("FAIL init_done_cycles: got %0d want 16", n8); end
    tests++; if (n16 != 12) begin fails++; $display("FAIL init_done_cycles_d12: got %0d want 12", n16); end
    for (int i = 0; i < 16; i++) begin
      rd8(0, 4'(i), d, lat);
      tests++; if (d !== 8'h00 || lat != LAT) begin fails++; $display("FAIL clear_readback[%0d]: got %h lat %0d want 00 lat %0d", i, d, lat, LAT); end
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [7:0] d, exp;
    for (int i = 0; i < 16; i++) wr8(0, 4'(i), 8'hA0 + 8'(i), 1'b1);
    for (int i = 0; i < 16; i++) begin
      exp = 8'hA0 + 8'(i);
      rd8(1, 4'(i), d, lat);
      tests++; if (d !== exp || lat != LAT) begin fails++; $display("FAIL b_read[%0d]: got %h lat %0d want %h lat %0d", i, d, lat, exp, LAT); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int j = 0; j <= 4 + LAT; j++) begin
      @(negedge clk);
      if (j >= LAT && j < 4 + LAT) begin
        exp = 8'hA0 + 8'(j - LAT);
        tests++; if (valid_b !== 1'b1 || dout_b !== exp) begin fails++; $display("FAIL b2b_read[%0d]: got v%b %h want v1 %h", j - LAT, valid_b, dout_b, exp); end
      end
      if (j == 4 + LAT) begin
        tests++; if (valid_b !== 1'b0 || dout_b !== 8'hA3) begin fails++; $display("FAIL b2b_hold: got v%b %h want v0 a3", valid_b, dout_b); end
      end
      if (j < 4) begin cs_b = 1; oe_b = 1; wr_en_b = 0; addr_b = 4'(j); end
      else idle_all();
    end
  endtask

  task automatic test_collision_ww();
    int lat;
    logic [7:0] d;
    @(negedge clk);
    cs_a = 1; wr_en_a = 1; addr_a = 4'd3; din_a = 8'h5A; be_a = 1'b1;
    cs_b = 1; wr_en_b = 1; addr_b = 4'd3; din_b = 8'hC3; be_b = 1'b1;
    @(negedge clk);
    idle_all();
    tests++; if (collision !== 1'b1) begin fails++; $display("FAIL ww_collision: got %b want 1", collision); end
    @(negedge clk);
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL collision_not_sticky: got %b want 0", collision); end
    rd8(0, 4'd3, d, lat);
    tests++; if (d !== 8'h5A) begin fails++; $display("FAIL ww_a_wins: got %h want 5a", d); end
    @(negedge clk);
    cs_a = 1; wr_en_a = 1; addr_a = 4'd8; din_a = 8'h08;
    cs_b = 1; wr_en_b = 1; addr_b = 4'd9; din_b = 8'h09;
    @(negedge clk);
    idle_all();
    tests++; if (collision !== 1'b0) begin fails++; $display("FAIL diff_addr_collision: got %b want 0", collision); end
    rd8(1, 4'd8, d, lat);
    tests++; if (d !== 8'h08) begin fails++; $display("FAIL diff_addr_a: got %h want 08", d); end
    rd8(0, 4'd9, d, lat);
    tests++; if (d !== 8'h09) begin fails++; $display("FAIL diff_addr_b: got %h want 09", d); end
  endtask

  task automatic test_read_first();
    int lat;
    logic [7:0] d;
    wr8(0, 4'd7, 8'h11, 1'b1);
    @(negedge clk);
    cs_a = 1; wr_en_a = 1; addr_a = 4'd7; din_a = 8'h22;
    cs_b = 1; oe_b = 1; addr_b = 4'd7;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c == 1) begin
        idle_all();
        tests++; if (collision !== 1'b1) begin fails++; $display("FAIL wr_collision: got %b want 1", collision); end
      end
    end
    tests++; if (valid_b !== 1'b1 || dout_b !== 8'h11) begin fails++; $display("FAIL read_first_b: got v%b %h want v1 11", valid_b, dout_b); end
    rd8(1, 4'd7, d, lat);
    tests++; if (d !== 8'h22) begin fails++; $display("FAIL after_write_b: got %h want 22", d); end
    @(negedge clk);
    cs_b = 1; wr_en_b = 1; addr_b = 4'd7; din_b = 8'h33;
    cs_a = 1; oe_a = 1; addr_a = 4'd7;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c == 1) idle_all();
    end
    tests++; if (valid_a !== 1'b1 || dout_a !== 8'h22) begin fails++; $display("FAIL read_first_a: got v%b %h want v1 22", valid_a, dout_a); end
    @(negedge clk);
    cs_a = 1; oe_a = 1; addr_a = 4'd7;
    cs_b = 1; oe_b = 1; addr_b = 4'd7;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c == 1) begin
        idle_all();
        tests++; if (collision !== 1'b0) begin fails++; $display("FAIL rr_collision: got %b want 0", collision); end
      end
    end
    tests++; if ({valid_a, valid_b} !== 2'b11 || dout_a !== 8'h33 || dout_b !== 8'h33) begin
      fails++; $display("FAIL both_read: got v%b%b %h %h want v11 33 33", valid_a, valid_b, dout_a, dout_b);
    end
  endtask

  task automatic test_byte_enables();
    int lat;
    logic [7:0] d;
    logic seen;
    wr8(0, 4'd5, 8'h77, 1'b1);
    wr8(0, 4'd5, 8'h99, 1'b0);
    rd8(0, 4'd5, d, lat);
    tests++; if (d !== 8'h77) begin fails++; $display("FAIL be_zero_noop: got %h want 77", d); end
    @(negedge clk);
    cs_a = 0; wr_en_a = 1; oe_a = 1; addr_a = 4'd5; din_a = 8'h55;
    @(negedge clk);
    idle_all();
    rd8(0, 4'd5, d, lat);
    tests++; if (d !== 8'h77) begin fails++; $display("FAIL cs_low_ignored: got %h want 77", d); end
    @(negedge clk);
    cs_a = 1; wr_en_a = 1; oe_a = 1; addr_a = 4'd5; din_a = 8'h66;
    seen = 0;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c == 1) idle_all();
      if (valid_a) seen = 1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL write_no_valid: got valid %b want 0", seen); end
    rd8(0, 4'd5, d, lat);
    tests++; if (d !== 8'h66) begin fails++; $display("FAIL wr_priority: got %h want 66", d); end
  endtask

  task automatic test_wide();
    int lat;
    logic [15:0] d;
    wr16(0, 4'd2, 16'h1234, 2'b11);
    wr16(0, 4'd2, 16'hABCD, 2'b01);
    rd16(0, 4'd2, d, lat);
    tests++; if (d !== 16'h12CD) begin fails++; $display("FAIL w16_be01: got %h want 12cd", d); end
    wr16(1, 4'd2, 16'hEE00, 2'b10);
    rd16(1, 4'd2, d, lat);
    tests++; if (d !== 16'hEECD) begin fails++; $display("FAIL w16_be10: got %h want eecd", d); end
    @(negedge clk);
    w_cs_a = 1; w_wr_a = 1; w_addr_a = 4'd4; w_din_a = 16'h0011; w_be_a = 2'b01;
    w_cs_b = 1; w_wr_b = 1; w_addr_b = 4'd4; w_din_b = 16'h2233; w_be_b = 2'b11;
    @(negedge clk);
    idle_all();
    tests++; if (w_collision !== 1'b1) begin fails++; $display("FAIL w16_collision: got %b want 1", w_collision); end
    rd16(0, 4'd4, d, lat);
    tests++; if (d !== 16'h2211) begin fails++; $display("FAIL w16_byte_merge: got %h want 2211", d); end
    wr16(0, 4'd13, 16'hBEEF, 2'b11);
    rd16(1, 4'd13, d, lat);
    tests++; if (d !== 16'h0000 || lat != LAT) begin fails++; $display("FAIL w16_out_of_range: got %h lat %0d want 0000 lat %0d", d, lat, LAT); end
  endtask

  task automatic test_reset_mid();
    int n8, n16, lat;
    logic [7:0] d;
    idle_all();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    #2 rst_n = 0;
    #1;
    tests++; if (init_done !== 1'b0) begin fails++; $display("FAIL mid_sweep_reset: got %b want 0", init_done); end
    @(negedge clk);
    rst_n = 1;
    wait_ready(n8, n16);
    tests++; if (n8 != 16) begin fails++; $display("FAIL restart_after_sweep_reset: got %0d want 16", n8); end
    wr8(0, 4'd3, 8'h5A, 1'b1);
    @(negedge clk);
    cs_b = 1; oe_b = 1; addr_b = 4'd3;
    lat = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) idle_all();
      if (valid_b) begin lat = c; break; end
    end
    tests++; if (lat != LAT || dout_b !== 8'h5A) begin fails++; $display("FAIL pre_reset_read: got %h lat %0d want 5a lat %0d", dout_b, lat, LAT); end
    #1 rst_n = 0;
    #1;
    tests++; if (dout_b !== 8'h00 || valid_b !== 1'b0 || init_done !== 1'b0) begin
      fails++; $display("FAIL async_reset_outputs: got %h v%b done%b want 00 v0 done0", dout_b, valid_b, init_done);
    end
    @(negedge clk);
    rst_n = 1;
    wait_ready(n8, n16);
    tests++; if (n8 != 16) begin fails++; $display("FAIL restart_after_op_reset: got %0d want 16", n8); end
    rd8(0, 4'd3, d, lat);
    tests++; if (d !== 8'h00 || lat != LAT) begin fails++; $display("FAIL recleared: got %h lat %0d want 00 lat %0d", d, lat, LAT); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_collision_ww();
    test_read_first();
    test_byte_enables();
    test_wide();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
